write_back: RTL and testbench

//  Final (WB) pipeline stage; sits directly downstream of the memory-access stage.

---
 rtl/write_back.sv | 165 ++++++++++++++++
 tb/tb_write_back.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_back.sv
// ============================================================================
// write_back : WB pipeline stage - registers MEM outputs, extracts load data,
//              drives the register-file write port and a retired counter.
// Optional debug trace ports enabled by macro WB_DEBUG_TRACE_EN.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module write_back #(
   parameter int          CNT_W    = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             stall,
   input  logic             mem_valid,
   input  logic [31:0]      inst_in,
   input  logic [31:0]      pc_in,
   input  logic [31:0]      final_result_in,
   input  logic [31:0]      mem_read_data_in,
   input  logic [4:0]       write_reg_in,
   input  logic             reg_write_in,
   input  logic             mem_to_reg_in,
   output logic             wb_valid,
   output logic             rf_we,
   output logic [4:0]       rf_waddr,
   output logic [31:0]      rf_wdata,
   output logic             align_err,
   output logic [31:0]      inst_out,
   output logic [31:0]      pc_out,
   output logic [CNT_W-1:0] retired_count
`ifdef WB_DEBUG_TRACE_EN
   ,
   output logic [31:0]      debug_wb_pc,
   output logic [3:0]       debug_wb_rf_wen,
   output logic [4:0]       debug_wb_rf_wnum,
   output logic [31:0]      debug_wb_rf_wdata
`endif
);

   localparam logic [5:0] C_OP_LB  = 6'b100000;
   localparam logic [5:0] C_OP_LH  = 6'b100001;
   localparam logic [5:0] C_OP_LW  = 6'b100011;
   localparam logic [5:0] C_OP_LBU = 6'b100100;
   localparam logic [5:0] C_OP_LHU = 6'b100101;

   logic             valid_q,      valid_d;
   logic [31:0]      inst_q,       inst_d;
   logic [31:0]      pc_q,         pc_d;
   logic [31:0]      result_q,     result_d;
   logic [31:0]      data_q,       data_d;
   logic [4:0]       waddr_q,      waddr_d;
   logic             reg_write_q,  reg_write_d;
   logic             mem_to_reg_q, mem_to_reg_d;
   logic [CNT_W-1:0] count_q,      count_d;

   always_comb begin
      valid_d      = valid_q;
      inst_d       = inst_q;
      pc_d         = pc_q;
      result_d     = result_q;
      data_d       = data_q;
      waddr_d      = waddr_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      count_d      = count_q;
      if (!stall) begin
         valid_d      = mem_valid;
         inst_d       = inst_in;
         pc_d         = pc_in;
         result_d     = final_result_in;
         data_d       = mem_read_data_in;
         waddr_d      = write_reg_in;
         // A bubble must never carry write/load control into WB
         reg_write_d  = mem_valid & reg_write_in;
         mem_to_reg_d = mem_valid & mem_to_reg_in;
         if (mem_valid) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_q      <= 1'b0;
         inst_q       <= 32'h0;
         pc_q         <= RESET_PC;
         result_q     <= 32'h0;
         data_q       <= 32'h0;
         waddr_q      <= 5'h0;
         reg_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         count_q      <= '0;
      end else begin
         valid_q      <= valid_d;
         inst_q       <= inst_d;
         pc_q         <= pc_d;
         result_q     <= result_d;
         data_q       <= data_d;
         waddr_q      <= waddr_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         count_q      <= count_d;
      end
   end

   logic [5:0]  w_op;
   logic [1:0]  w_a;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic        w_misaligned;

   assign w_op   = inst_q[31:26];
   assign w_a    = result_q[1:0];
   assign w_half = w_a[1] ? data_q[31:16] : data_q[15:0];

   always_comb begin
      case (w_a)
         2'd0:    w_byte = data_q[7:0];
         2'd1:    w_byte = data_q[15:8];
         2'd2:    w_byte = data_q[23:16];
         default: w_byte = data_q[31:24];
      endcase
   end

   always_comb begin
      w_load       = data_q;
      w_misaligned = 1'b0;
      case (w_op)
         C_OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
         C_OP_LBU: w_load = {24'h0, w_byte};
         C_OP_LH: begin
            w_load       = {{16{w_half[15]}}, w_half};
            w_misaligned = w_a[0];
         end
         C_OP_LHU: begin
            w_load       = {16'h0, w_half};
            w_misaligned = w_a[0];
         end
         C_OP_LW:  w_misaligned = (w_a != 2'd0);
         default:  w_load = data_q;
      endcase
   end

   assign align_err     = valid_q & mem_to_reg_q & w_misaligned;
   assign rf_wdata      = mem_to_reg_q ? w_load : result_q;
   assign rf_waddr      = waddr_q;
   assign rf_we         = valid_q & reg_write_q & (waddr_q != 5'd0) & ~align_err;
   assign wb_valid      = valid_q;
   assign inst_out      = inst_q;
   assign pc_out        = pc_q;
   assign retired_count = count_q;

`ifdef WB_DEBUG_TRACE_EN
   // Trace pulses once per instruction even while a stall holds rf_we high
   assign debug_wb_pc       = pc_q;
   assign debug_wb_rf_wen   = {4{rf_we & ~stall}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;
`endif

endmodule

`default_nettype wire

// File: tb/tb_write_back.sv
// ============================================================================
// tb_write_back : self-checking bench for write_back (directed + randomized).
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_write_back;

   localparam logic [31:0] C_RESET_PC = 32'hBFC0_0000;
   localparam logic [5:0]  C_LB  = 6'b100000;
   localparam logic [5:0]  C_LH  = 6'b100001;
   localparam logic [5:0]  C_LW  = 6'b100011;
   localparam logic [5:0]  C_LBU = 6'b100100;
   localparam logic [5:0]  C_LHU = 6'b100101;

   logic        clk;
   logic        rstn;
   logic        stall;
   logic        mem_valid;
   logic [31:0] inst_in;
   logic [31:0] pc_in;
   logic [31:0] final_result_in;
   logic [31:0] mem_read_data_in;
   logic [4:0]  write_reg_in;
   logic        reg_write_in;
   logic        mem_to_reg_in;

   logic        wb_valid,  rf_we,  align_err;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata,  inst_out,  pc_out,  retired_count;
   logic        wb_valid2, rf_we2, align_err2;
   logic [4:0]  rf_waddr2;
   logic [31:0] rf_wdata2, inst_out2, pc_out2;
   logic [3:0]  retired_count2;

`ifdef WB_DEBUG_TRACE_EN
   logic [31:0] debug_wb_pc,  debug_wb_rf_wdata,  debug_wb_pc2,  debug_wb_rf_wdata2;
   logic [3:0]  debug_wb_rf_wen,  debug_wb_rf_wen2;
   logic [4:0]  debug_wb_rf_wnum, debug_wb_rf_wnum2;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Reference state: what the WB stage should be holding
   logic        m_valid, m_rw, m_m2r;
   logic [31:0] m_inst, m_pc, m_res, m_data, m_cnt;
   logic [4:0]  m_wa;

   write_back #(.CNT_W(32), .RESET_PC(C_RESET_PC)) dut (
      .clk(clk), .rstn(rstn), .stall(stall), .mem_valid(mem_valid),
      .inst_in(inst_in), .pc_in(pc_in), .final_result_in(final_result_in),
      .mem_read_data_in(mem_read_data_in), .write_reg_in(write_reg_in),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .wb_valid(wb_valid), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .align_err(align_err), .inst_out(inst_out), .pc_out(pc_out),
      .retired_count(retired_count)
`ifdef WB_DEBUG_TRACE_EN
      , .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
   );

   write_back #(.CNT_W(4), .RESET_PC(C_RESET_PC)) dut4 (
      .clk(clk), .rstn(rstn), .stall(stall), .mem_valid(mem_valid),
      .inst_in(inst_in), .pc_in(pc_in), .final_result_in(final_result_in),
      .mem_read_data_in(mem_read_data_in), .write_reg_in(write_reg_in),
      .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
      .wb_valid(wb_valid2), .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
      .align_err(align_err2), .inst_out(inst_out2), .pc_out(pc_out2),
      .retired_count(retired_count2)
`ifdef WB_DEBUG_TRACE_EN
      , .debug_wb_pc(debug_wb_pc2), .debug_wb_rf_wen(debug_wb_rf_wen2),
      .debug_wb_rf_wnum(debug_wb_rf_wnum2), .debug_wb_rf_wdata(debug_wb_rf_wdata2)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Load result from the architectural rules using shifts and integer sign handling
   function automatic logic [31:0] f_wdata();
      int a;
      int v;
      if (!m_m2r) return m_res;
      a = int'(m_res[1:0]);
      case (m_inst[31:26])
         C_LB, C_LBU: begin
            v = int'((m_data >> (8 * a)) & 32'hFF);
            if (m_inst[31:26] == C_LB && v > 127) v = v - 256;
            return 32'(v);
         end
         C_LH, C_LHU: begin
            v = int'((m_data >> ((a >= 2) ? 16 : 0)) & 32'hFFFF);
            if (m_inst[31:26] == C_LH && v > 32767) v = v - 65536;
            return 32'(v);
         end
         default: return m_data;
      endcase
   endfunction

   function automatic logic f_align();
      logic is_half;
      is_half = (m_inst[31:26] == C_LH) || (m_inst[31:26] == C_LHU);
      return m_valid && m_m2r &&
             ((is_half && m_res[0]) || (m_inst[31:26] == C_LW && m_res[1:0] != 2'd0));
   endfunction

   function automatic logic f_we();
      return m_valid && m_rw && (m_wa != 5'd0) && !f_align();
   endfunction

   // One clock edge: advance the reference, then settle past the edge
   task automatic tick();
      @(posedge clk);
      if (!rstn) begin
         m_valid = 1'b0; m_inst = 32'h0; m_pc = C_RESET_PC; m_res = 32'h0;
         m_data = 32'h0; m_wa = 5'h0; m_rw = 1'b0; m_m2r = 1'b0; m_cnt = 32'h0;
      end else if (!stall) begin
         m_valid = mem_valid; m_inst = inst_in; m_pc = pc_in; m_res = final_result_in;
         m_data = mem_read_data_in; m_wa = write_reg_in;
         m_rw = mem_valid & reg_write_in; m_m2r = mem_valid & mem_to_reg_in;
         if (mem_valid) m_cnt = m_cnt + 32'd1;
      end
      #1;
   endtask

   task automatic drive(input logic mv, input logic [5:0] op, input logic [4:0] rd,
                        input logic rw, input logic m2r, input logic [31:0] res,
                        input logic [31:0] data);
      mem_valid        = mv;
      inst_in          = {op, 26'($urandom)};
      pc_in            = $urandom;
      write_reg_in     = rd;
      reg_write_in     = rw;
      mem_to_reg_in    = m2r;
      final_result_in  = res;
      mem_read_data_in = data;
   endtask

   task automatic test_reset();
      rstn = 1'b0; stall = 1'b1;
      drive(1'b1, 6'h00, 5'd9, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0);
      tick();
      total_cnt++;
      if ({wb_valid, rf_we, pc_out, retired_count} !== {1'b0, 1'b0, C_RESET_PC, 32'd0})
         $display("FAIL reset valid/we/pc/count got %b %b %h %0d want 0 0 %h 0",
                  wb_valid, rf_we, pc_out, retired_count, C_RESET_PC);
      else pass_cnt++;
      total_cnt++;
      if ({rf_waddr, rf_wdata, align_err} !== 38'd0)
         $display("FAIL reset rf_port got %h %h %b want 0", rf_waddr, rf_wdata, align_err);
      else pass_cnt++;
   endtask

   task automatic test_alu_write();
      rstn = 1'b1; stall = 1'b0;
      drive(1'b1, 6'h00, 5'd5, 1'b1, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF);
      tick();
      total_cnt++;
      if ({rf_we, rf_waddr, rf_wdata, retired_count} !== {1'b1, 5'd5, 32'h1234_5678, 32'd1})
         $display("FAIL alu_write got we=%b addr=%0d data=%h cnt=%0d want 1 5 12345678 1",
                  rf_we, rf_waddr, rf_wdata, retired_count);
      else pass_cnt++;
   endtask

   task automatic test_loads();
      logic [5:0]  ops  [5] = '{C_LB, C_LBU, C_LH, C_LHU, C_LW};
      logic [1:0]  offs [5] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
      logic [31:0] want [5] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, ops[i], 5'd12, 1'b1, 1'b1, {28'h1000_020, 2'b00, offs[i]}, 32'h80FF_7F01);
         tick();
         total_cnt++;
         if ({rf_we, align_err, rf_wdata} !== {1'b1, 1'b0, want[i]})
            $display("FAIL load%0d we/err/data got %b %b %h want 1 0 %h",
                     i, rf_we, align_err, rf_wdata, want[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_misaligned_zero();
      logic [31:0] cnt_before;
      drive(1'b1, C_LW, 5'd3, 1'b1, 1'b1, 32'h0000_0102, 32'h80FF_7F01);
      tick();
      total_cnt++;
      if ({align_err, rf_we} !== 2'b10)
         $display("FAIL lw_misaligned err/we got %b %b want 1 0", align_err, rf_we);
      else pass_cnt++;
      drive(1'b1, C_LHU, 5'd3, 1'b1, 1'b1, 32'h0000_0101, 32'h80FF_7F01);
      tick();
      total_cnt++;
      if ({align_err, rf_we} !== 2'b10)
         $display("FAIL lhu_misaligned err/we got %b %b want 1 0", align_err, rf_we);
      else pass_cnt++;
      cnt_before = m_cnt;
      drive(1'b1, 6'h00, 5'd0, 1'b1, 1'b0, 32'hCAFE_0000, 32'h0);
      tick();
      total_cnt++;
      if ({rf_we, wb_valid, retired_count} !== {1'b0, 1'b1, cnt_before + 32'd1})
         $display("FAIL rd0_write we/valid/cnt got %b %b %0d want 0 1 %0d",
                  rf_we, wb_valid, retired_count, cnt_before + 32'd1);
      else pass_cnt++;
   endtask

   task automatic test_stall();
      logic [31:0] cnt_before;
      cnt_before = m_cnt;
      drive(1'b1, 6'h00, 5'd7, 1'b1, 1'b0, 32'hA5A5_0F0F, 32'h0);
      tick();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, C_LB, 5'd20, 1'b1, 1'b1, $urandom, $urandom);
         tick();
         total_cnt++;
         if ({rf_we, rf_waddr, rf_wdata, retired_count} !==
             {1'b1, 5'd7, 32'hA5A5_0F0F, cnt_before + 32'd1})
            $display("FAIL stall_hold%0d got we=%b addr=%0d data=%h cnt=%0d want 1 7 a5a50f0f %0d",
                     i, rf_we, rf_waddr, rf_wdata, retired_count, cnt_before + 32'd1);
         else pass_cnt++;
      end
      stall = 1'b0;
   endtask

   task automatic test_bubble();
      logic [31:0] cnt_before;
      cnt_before = m_cnt;
      drive(1'b0, 6'h00, 5'd9, 1'b1, 1'b0, 32'h1111_2222, 32'h0);
      tick();
      total_cnt++;
      if ({wb_valid, rf_we, retired_count} !== {1'b0, 1'b0, cnt_before})
         $display("FAIL bubble valid/we/cnt got %b %b %0d want 0 0 %0d",
                  wb_valid, rf_we, retired_count, cnt_before);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b1, 6'h00, 5'd4, 1'b1, 1'b0, 32'h7777_7777, 32'h0);
      tick();
      stall = 1'b1; rstn = 1'b0;
      tick();
      total_cnt++;
      if ({wb_valid, rf_we, retired_count, pc_out} !== {1'b0, 1'b0, 32'd0, C_RESET_PC})
         $display("FAIL reset_mid_stall valid/we/cnt/pc got %b %b %0d %h want 0 0 0 %h",
                  wb_valid, rf_we, retired_count, pc_out, C_RESET_PC);
      else pass_cnt++;
      rstn = 1'b1; stall = 1'b0;
   endtask

   task automatic test_wrap();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         drive(1'b1, 6'h00, 5'd1, 1'b1, 1'b0, 32'(i), 32'h0);
         tick();
         if (i == 15 || i == 16) begin
            total_cnt++;
            if ({retired_count2, retired_count} !== {4'(i % 16), 32'(i)})
               $display("FAIL wrap_after_%0d cnt4/cnt32 got %0d %0d want %0d %0d",
                        i, retired_count2, retired_count, i % 16, i);
            else pass_cnt++;
         end
      end
   endtask

   task automatic test_random();
      logic [135:0] act, exp;
      logic [107:0] act4, exp4;
      logic [5:0]   op;
      int           sel;
      int           errs;
      errs = 0;
      for (int i = 0; i < 400; i++) begin
         rstn  = ($urandom_range(0, 39) != 0);
         stall = ($urandom_range(0, 3) == 0);
         sel   = $urandom_range(0, 6);
         case (sel)
            0: op = C_LB;   1: op = C_LBU;  2: op = C_LH;
            3: op = C_LHU;  4: op = C_LW;   default: op = 6'($urandom);
         endcase
         drive(1'($urandom), op, 5'($urandom), 1'($urandom), 1'($urandom),
               $urandom, $urandom);
         tick();
         act = {wb_valid, rf_we, rf_waddr, rf_wdata, align_err, inst_out, pc_out, retired_count};
         exp = {m_valid, f_we(), m_wa, f_wdata(), f_align(), m_inst, m_pc, m_cnt};
         total_cnt++;
         if (act !== exp) begin
            if (errs < 10)
               $display("FAIL random%0d dut32 got %h want %h", i, act, exp);
            errs++;
         end else pass_cnt++;
         act4 = {wb_valid2, rf_we2, rf_waddr2, rf_wdata2, align_err2, inst_out2, pc_out2,
                 retired_count2};
         exp4 = {m_valid, f_we(), m_wa, f_wdata(), f_align(), m_inst, m_pc, m_cnt[3:0]};
         total_cnt++;
         if (act4 !== exp4) begin
            if (errs < 10)
               $display("FAIL random%0d dut4 got %h want %h", i, act4, exp4);
            errs++;
         end else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_alu_write();
      test_loads();
      test_misaligned_zero();
      test_stall();
      test_bubble();
      test_reset_mid_stall();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

`default_nettype wire
